isi_scheduler: RTL and testbench

Multi-channel inter-spike-interval (ISI) measurement controller for the landscape sampling path. It owns N_CH per-channel ISI counters and a shared tick prescaler, and snapshots/clears a channel's counter on each spike. Completed intervals are queued one per channel and serialized through a round-robin arbiter onto a single valid/ready record stream for the downstream histogram/readout logic.

---
 rtl/isi_pkg.sv | 19 +
 rtl/isi_scheduler_if.sv | 20 ++
 rtl/isi_chan_cnt.sv | 41 ++++
 rtl/isi_scheduler.sv | 167 ++++++++++++++++
 tb/tb_isi_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/isi_pkg.sv
// Shared types and sizing helpers for the ISI measurement path.
package isi_pkg;

  typedef enum logic [1:0] {
    CH_UNARMED = 2'd0,
    CH_ARMED   = 2'd1,
    CH_PENDING = 2'd2
  } ch_state_e;

  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Packed record layout is {ch, isi, of}.
  function automatic int unsigned rec_w(input int unsigned n_ch, input int unsigned bit_isi);
    return ch_w(n_ch) + bit_isi + 1;
  endfunction

endpackage

// File: rtl/isi_scheduler_if.sv
// Valid/ready record stream carrying completed intervals to the readout logic.
interface isi_scheduler_if
  import isi_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned BIT_ISI = 8
) ();

  localparam int unsigned CH_W = ch_w(N_CH);

  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [BIT_ISI-1:0] out_isi;
  logic               out_of;

  modport master (output out_valid, out_ch, out_isi, out_of, input out_ready);
  modport slave  (input out_valid, out_ch, out_isi, out_of, output out_ready);

endinterface

// File: rtl/isi_chan_cnt.sv
// Per-channel interval counter with sticky wrap flag; clear wins over count.
module isi_chan_cnt #(
  parameter int unsigned BIT_ISI = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ce_i,
  input  logic               sclr_i,
  output logic [BIT_ISI-1:0] q_o,
  output logic               of_o
);

  logic [BIT_ISI-1:0] q_q, q_d;
  logic               of_q, of_d;

  always_comb begin
    q_d  = q_q;
    of_d = of_q;
    if (sclr_i) begin
      q_d  = '0;
      of_d = 1'b0;
    end else if (ce_i) begin
      q_d = q_q + BIT_ISI'(1);
      if (&q_q) of_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q  <= '0;
      of_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      of_q <= of_d;
    end
  end

  assign q_o  = q_q;
  assign of_o = of_q;

endmodule

// File: rtl/isi_scheduler.sv
// Multi-channel ISI measurement: prescaler, per-channel arm/snapshot FSMs and
// a round-robin arbiter draining one-deep per-channel slots onto a record stream.
module isi_scheduler
  import isi_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned BIT_ISI  = 8,
  parameter int unsigned TICK_DIV = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic [N_CH-1:0]     spike,
  isi_scheduler_if.master     rec,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned CH_W  = ch_w(N_CH);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = CH_W + 1;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               tick;
  logic [N_CH-1:0]    hit;
  logic [BIT_ISI-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]    cnt_of;

  ch_state_e          st_q [N_CH];
  ch_state_e          st_d [N_CH];
  logic [BIT_ISI-1:0] snap_isi_q [N_CH];
  logic [BIT_ISI-1:0] snap_isi_d [N_CH];
  logic [N_CH-1:0]    snap_of_q, snap_of_d;

  logic               valid_q, valid_d;
  logic [CH_W-1:0]    och_q, och_d;
  logic [BIT_ISI-1:0] oisi_q, oisi_d;
  logic               oof_q, oof_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic [7:0]         drop_q, drop_d;
  logic [8:0]         drop_sum;

  logic               can_grant, gnt_any, grant, gnt_me;
  logic [CH_W-1:0]    gnt_idx, cand;
  logic [CNT_W-1:0]   drops;

  assign tick = en && (pre_q == PRE_W'(TICK_DIV - 1));
  assign hit  = spike & {N_CH{en}};

  always_comb begin
    pre_d = pre_q;
    if (tick)    pre_d = '0;
    else if (en) pre_d = pre_q + PRE_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    isi_chan_cnt #(.BIT_ISI(BIT_ISI)) u_cnt (
      .clk    (clk),
      .clr    (clr),
      .ce_i   (tick),
      .sclr_i (hit[i]),
      .q_o    (cnt_q[i]),
      .of_o   (cnt_of[i])
    );
  end

  // First pending channel strictly after the last grant, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = CH_W'((32'(last_q) + k) % N_CH);
      if (!gnt_any && st_q[cand] == CH_PENDING) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign can_grant = !valid_q || rec.out_ready;
  assign grant     = can_grant && gnt_any;

  always_comb begin
    st_d       = st_q;
    snap_isi_d = snap_isi_q;
    snap_of_d  = snap_of_q;
    drops      = '0;
    gnt_me     = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      gnt_me = grant && (gnt_idx == CH_W'(i));
      case (st_q[i])
        CH_UNARMED: if (hit[i]) st_d[i] = CH_ARMED;
        CH_ARMED: begin
          if (hit[i]) begin
            st_d[i]       = CH_PENDING;
            snap_isi_d[i] = cnt_q[i];
            snap_of_d[i]  = cnt_of[i];
          end
        end
        CH_PENDING: begin
          // A spike landing with its own grant refills the slot it just vacated.
          if (hit[i] && gnt_me) begin
            snap_isi_d[i] = cnt_q[i];
            snap_of_d[i]  = cnt_of[i];
          end else if (gnt_me) begin
            st_d[i] = CH_ARMED;
          end else if (hit[i]) begin
            drops = drops + CNT_W'(1);
          end
        end
        default: st_d[i] = CH_UNARMED;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    och_d   = och_q;
    oisi_d  = oisi_q;
    oof_d   = oof_q;
    last_d  = last_q;
    if (can_grant) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        och_d  = gnt_idx;
        oisi_d = snap_isi_q[gnt_idx];
        oof_d  = snap_of_q[gnt_idx];
        last_d = gnt_idx;
      end
    end
    drop_sum = {1'b0, drop_q} + 9'(drops);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_q      <= '0;
      st_q       <= '{default: CH_UNARMED};
      snap_isi_q <= '{default: '0};
      snap_of_q  <= '0;
      valid_q    <= 1'b0;
      och_q      <= '0;
      oisi_q     <= '0;
      oof_q      <= 1'b0;
      last_q     <= CH_W'(N_CH - 1);
      drop_q     <= '0;
    end else begin
      pre_q      <= pre_d;
      st_q       <= st_d;
      snap_isi_q <= snap_isi_d;
      snap_of_q  <= snap_of_d;
      valid_q    <= valid_d;
      och_q      <= och_d;
      oisi_q     <= oisi_d;
      oof_q      <= oof_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
    end
  end

  assign rec.out_valid = valid_q;
  assign rec.out_ch    = och_q;
  assign rec.out_isi   = oisi_q;
  assign rec.out_of    = oof_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_isi_scheduler.sv
// Bench for isi_scheduler: table of single-channel intervals plus hand-written
// arbitration, drop, enable and reset sequences, checked through a record scoreboard.
module tb_isi_scheduler;
  import isi_pkg::*;

  localparam int unsigned NC    = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned TD    = 4;
  localparam int unsigned CH_W  = ch_w(NC);
  localparam int unsigned REC_W = rec_w(NC, BW);

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic [NC-1:0] spike;
  logic [7:0]    drop_cnt;

  isi_scheduler_if #(.N_CH(NC), .BIT_ISI(BW)) rec ();

  isi_scheduler #(.N_CH(NC), .BIT_ISI(BW), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .spike    (spike),
    .rec      (rec),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int pre_m  = 0;
  int tick_cnt = 0;
  int clr_ref [NC];
  logic [REC_W-1:0] sb [$];

  typedef struct {
    int ch;
    int gap;
    int isi;
    int of;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // One clock; tracks the expected prescaler phase and cumulative tick count.
  task automatic step();
    bit e;
    e = en;
    @(posedge clk);
    if (e) begin
      if (pre_m == TD - 1) begin
        pre_m = 0;
        tick_cnt++;
      end else begin
        pre_m++;
      end
    end
    #1;
  endtask

  task automatic pulse(input logic [NC-1:0] m);
    bit e;
    e = en;
    spike = m;
    step();
    spike = '0;
    if (e) for (int c = 0; c < NC; c++) if (m[c]) clr_ref[c] = tick_cnt;
  endtask

  task automatic do_clr();
    clr   = 1'b1;
    spike = '0;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    pre_m = 0;
  endtask

  function automatic logic [REC_W-1:0] mk_exp(input int c);
    int d;
    d = tick_cnt - clr_ref[c];
    return {CH_W'(c), BW'(d % (1 << BW)), (d >= (1 << BW))};
  endfunction

  // Scoreboard: every accepted record must match the oldest expectation.
  always @(negedge clk) begin
    logic [CH_W-1:0] e_ch;
    logic [BW-1:0]   e_isi;
    logic            e_of;
    if (!clr && rec.out_valid && rec.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rec: got ch=%0d isi=%0d of=%0d, required no record",
                 rec.out_ch, rec.out_isi, rec.out_of);
      end else begin
        {e_ch, e_isi, e_of} = sb.pop_front();
        check("rec_ch", int'(rec.out_ch), int'(e_ch));
        check("rec_isi", int'(rec.out_isi), int'(e_isi));
        check("rec_of", int'(rec.out_of), int'(e_of));
      end
    end
  end

  initial begin
    tbl[0] = '{1, 40, 10, 0};
    tbl[1] = '{2, 1, 0, 0};
    tbl[2] = '{3, 3, 1, 0};
    tbl[3] = '{0, 18, 4, 0};
    tbl[4] = '{2, 1046, 5, 1};
    for (int c = 0; c < NC; c++) clr_ref[c] = 0;

    clr = 1'b1;
    en = 1'b1;
    spike = '0;
    rec.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    pre_m = 0;
    check("rst_valid", int'(rec.out_valid), 0);
    check("rst_ch", int'(rec.out_ch), 0);
    check("rst_isi", int'(rec.out_isi), 0);
    check("rst_of", int'(rec.out_of), 0);
    check("rst_drop", int'(drop_cnt), 0);

    // Single-channel intervals, armed at prescaler phase 1.
    foreach (tbl[i]) begin
      do_clr();
      rec.out_ready = 1'b1;
      while (pre_m != 1) step();
      pulse(NC'(1) << tbl[i].ch);
      repeat (tbl[i].gap - 1) step();
      check("arm_silent", int'(rec.out_valid), 0);
      sb.push_back({CH_W'(tbl[i].ch), BW'(tbl[i].isi), 1'(tbl[i].of)});
      pulse(NC'(1) << tbl[i].ch);
      check("lat_edge0", int'(rec.out_valid), 0);
      step();
      check("lat_edge1_valid", int'(rec.out_valid), 1);
      check("lat_edge1_ch", int'(rec.out_ch), tbl[i].ch);
      step();
      check("tbl_drained", int'(rec.out_valid), 0);
    end

    // Round-robin: simultaneous spikes, then rotation after last grant.
    do_clr();
    rec.out_ready = 1'b1;
    pulse(4'hF);
    repeat (6) step();
    for (int c = 0; c < NC; c++) sb.push_back(mk_exp(c));
    pulse(4'hF);
    for (int c = 0; c < NC; c++) begin
      step();
      check("rr_valid", int'(rec.out_valid), 1);
      check("rr_ch", int'(rec.out_ch), c);
    end
    step();
    check("rr_idle", int'(rec.out_valid), 0);
    sb.push_back(mk_exp(1));
    pulse(4'b0010);
    step();
    check("rr_single_ch", int'(rec.out_ch), 1);
    sb.push_back(mk_exp(3));
    sb.push_back(mk_exp(0));
    pulse(4'b1001);
    step();
    check("rr_rot_first", int'(rec.out_ch), 3);
    step();
    check("rr_rot_second", int'(rec.out_ch), 0);
    step();
    check("rr_rot_idle", int'(rec.out_valid), 0);

    // Drops while the output is stalled; first snapshot must survive.
    do_clr();
    rec.out_ready = 1'b1;
    pulse(4'b0101);
    repeat (20) step();
    rec.out_ready = 1'b0;
    sb.push_back(mk_exp(0));
    pulse(4'b0001);
    step();
    check("stall_valid", int'(rec.out_valid), 1);
    sb.push_back(mk_exp(2));
    pulse(4'b0100);
    repeat (3) step();
    pulse(4'b0100);
    step();
    pulse(4'b0100);
    check("drop_two", int'(drop_cnt), 2);
    check("hold_ch", int'(rec.out_ch), 0);
    check("hold_valid", int'(rec.out_valid), 1);
    rec.out_ready = 1'b1;
    step();
    check("release_ch", int'(rec.out_ch), 2);
    rec.out_ready = 1'b0;
    sb.push_back(mk_exp(2));
    pulse(4'b0100);
    repeat (300) pulse(4'b0100);
    check("drop_sat", int'(drop_cnt), 255);
    check("sat_hold_valid", int'(rec.out_valid), 1);
    rec.out_ready = 1'b1;
    step();
    check("drain_b_valid", int'(rec.out_valid), 1);
    check("drain_b_ch", int'(rec.out_ch), 2);
    step();
    check("drain_idle", int'(rec.out_valid), 0);

    // Enable gating: 40 frozen cycles with ignored spikes.
    do_clr();
    rec.out_ready = 1'b1;
    pulse(4'b1000);
    repeat (10) step();
    en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 7 == 0) pulse(4'b1010);
      else step();
    end
    check("en0_quiet", int'(rec.out_valid), 0);
    en = 1'b1;
    repeat (6) step();
    sb.push_back({CH_W'(3), BW'(4), 1'b0});
    pulse(4'b1000);
    step();
    check("en_rec_valid", int'(rec.out_valid), 1);
    check("en_rec_ch", int'(rec.out_ch), 3);
    step();

    // Asynchronous clear with a record on the bus and channels pending.
    do_clr();
    rec.out_ready = 1'b0;
    pulse(4'b0111);
    repeat (8) step();
    pulse(4'b0111);
    step();
    pulse(4'b0010);
    check("pre_clr_valid", int'(rec.out_valid), 1);
    check("pre_clr_drop", int'(drop_cnt), 1);
    clr = 1'b1;
    #2;
    check("clr_valid", int'(rec.out_valid), 0);
    check("clr_ch", int'(rec.out_ch), 0);
    check("clr_isi", int'(rec.out_isi), 0);
    check("clr_of", int'(rec.out_of), 0);
    check("clr_drop", int'(drop_cnt), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    pre_m = 0;
    rec.out_ready = 1'b1;
    pulse(4'b0010);
    repeat (4) begin
      step();
      check("rearm_only", int'(rec.out_valid), 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
